// File: rtl/intr_arbiter_ctrl.sv
// Fixed-priority interrupt arbiter: req/ack handshake to the core,
// CLR pulses to the generator, in-service tracking until MRET.
//
// Ports: CLK, RST_N (async, active low), INTR/MASK/GIE (request inputs),
// INT_REQ/INT_ACK/INT_ID/INT_ADDR (core handshake), MRET (handler return),
// CLR (clear pulses), IN_SERVICE (in-service bits), MRET_ERR (sticky error).
// Build option: define INTR_NEST_EN to let higher-priority sources preempt.
module intr_arbiter_ctrl #(
  parameter int          NUM_SRC    = 6,
  parameter int          ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] INTR,
  input  logic [NUM_SRC-1:0] MASK,
  input  logic               GIE,
  output logic               INT_REQ,
  input  logic               INT_ACK,
  output logic [ID_W-1:0]    INT_ID,
  output logic [31:0]        INT_ADDR,
  input  logic               MRET,
  output logic [NUM_SRC-1:0] CLR,
  output logic [NUM_SRC-1:0] IN_SERVICE,
  output logic               MRET_ERR
);

  localparam logic [NUM_SRC-1:0] ONE = NUM_SRC'(1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t state, state_nxt;

  logic [NUM_SRC-1:0] in_svc, in_svc_nxt;
  logic [NUM_SRC-1:0] isv_low, elig;
  logic [NUM_SRC-1:0] cand_oh, req_oh;
  logic [ID_W-1:0]    cand_id, req_id;
  logic [31:0]        cand_addr, req_addr;
  logic               mret_err;
  logic               take, fire;

  // lowest set in-service bit (highest-priority active handler)
  assign isv_low = in_svc & (~in_svc + ONE);

`ifdef INTR_NEST_EN
  logic [NUM_SRC-1:0] below;

  // all ones when nothing is in service, else bits strictly below isv_low
  assign below = isv_low - ONE;
  assign elig  = INTR & MASK & ~in_svc & below;
`else
  assign elig  = (in_svc == '0) ? (INTR & MASK) : '0;
`endif

  // downward scan so the lowest index wins
  always_comb begin
    cand_oh   = '0;
    cand_id   = '0;
    cand_addr = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        cand_oh   = ONE << i;
        cand_id   = ID_W'(i + 1);
        cand_addr = VEC_BASE + VEC_STRIDE * 32'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    fire      = 1'b0;
    unique case (state)
      IDLE: begin
        if (GIE && (elig != '0)) begin
          take      = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // ack beats a simultaneous GIE drop
        if (INT_ACK) begin
          fire      = 1'b1;
          state_nxt = IDLE;
        end else if (!GIE) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // MRET clear uses the old value, then the accepted bit is ORed in
  always_comb begin
    in_svc_nxt = in_svc;
    if (MRET) in_svc_nxt = in_svc & ~isv_low;
    if (fire) in_svc_nxt = in_svc_nxt | req_oh;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_id   <= '0;
      req_addr <= '0;
      req_oh   <= '0;
      in_svc   <= '0;
      mret_err <= 1'b0;
    end else begin
      if (take) begin
        req_id   <= cand_id;
        req_addr <= cand_addr;
        req_oh   <= cand_oh;
      end
      in_svc <= in_svc_nxt;
      if (MRET && (in_svc == '0)) mret_err <= 1'b1;
    end
  end

  assign INT_REQ    = (state == REQ);
  assign INT_ID     = INT_REQ ? req_id : '0;
  assign INT_ADDR   = INT_REQ ? req_addr : '0;
  assign CLR        = fire ? req_oh : '0;
  assign IN_SERVICE = in_svc;
  assign MRET_ERR   = mret_err;

endmodule

// File: doc/intr_arbiter_ctrl.md
Name: intr_arbiter_ctrl

Overview:
- CPU-facing end of the interrupt path.
- Consumes the six registered pending lines INTR1..INTR6 from the interrupt signal generator and performs fixed-priority arbitration (INTR1 highest).
- Presents one request, with its id and handler address, to the RISC-V core through a req/ack handshake.
- Returns one-cycle CLR pulses to the generator and tracks in-service levels until the handler executes MRET.

Parameters:
- NUM_SRC, 6: number of interrupt sources; bit i corresponds to INTR(i+1).
- ID_W, 3: width of INT_ID; must satisfy 2^ID_W > NUM_SRC.
- VEC_BASE, 32'h0000_0100: handler address of source 1.
- VEC_STRIDE, 32'h0000_0010: address step between consecutive sources.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- INTR  in  NUM_SRC  pending lines from the generator; bit0 = INTR1.
- MASK  in  NUM_SRC  per-source enable; 1 = enabled.
- GIE  in  1  global interrupt enable from CSR.
- INT_REQ  out  1  interrupt request to the core.
- INT_ACK  in  1  core accepts the request at an instruction boundary.
- INT_ID  out  ID_W  1-based id of the request; 0 when idle.
- INT_ADDR  out  32  handler address = VEC_BASE + (INT_ID-1)*VEC_STRIDE.
- MRET  in  1  one-cycle pulse when the handler returns.
- CLR  out  NUM_SRC  one-cycle clear pulses to the generator (CLR1..CLR6).
- IN_SERVICE  out  NUM_SRC  in-service bits.
- MRET_ERR  out  1  sticky flag: MRET received with IN_SERVICE == 0.

Behaviour:
- Reset (RST_N low, asynchronous, at any time including mid-handshake):
  - State = IDLE.
  - INT_REQ = 0, INT_ID = 0, INT_ADDR = 0, CLR = 0, IN_SERVICE = 0, MRET_ERR = 0.
- Eligible set E = INTR & MASK & ~IN_SERVICE, restricted to indices below the lowest set IN_SERVICE bit. Candidate = lowest set bit of E.
- States:
  - IDLE: if GIE=1 and E≠0, latch candidate id and address. Next state REQ; INT_REQ=1 from the following cycle (one-cycle latency from sampled INTR).
  - REQ:
    - INT_REQ, INT_ID and INT_ADDR are held stable; no re-arbitration, even if a higher-priority source arrives.
    - INT_ACK=1: CLR[id-1]=1 for exactly that cycle, IN_SERVICE[id-1] set at the same edge, next state IDLE, INT_ID returns to 0.
    - GIE=0 with no INT_ACK: request withdrawn, next state IDLE, no CLR, no IN_SERVICE change.
    - GIE=0 with INT_ACK in the same cycle: the ack wins.
- INT_ACK received in IDLE is ignored.
- MRET:
  - Clears the lowest-index set bit of the pre-edge IN_SERVICE.
  - If IN_SERVICE == 0: no change and MRET_ERR is set (sticky until reset).
  - MRET and ACK in the same cycle: the clear is computed on the old value, then the ack bit is set. Both take effect.
- CLR is never asserted for more than one consecutive cycle per acceptance.
- The generator's INTR bit drops one cycle after CLR. The source is excluded via IN_SERVICE meanwhile, so no double-accept occurs.
- A source is not re-requested while its IN_SERVICE bit is set. A new edge captured meanwhile stays pending and is served after MRET.
- Back-to-back operation: after an ack, a new candidate is presented two cycles later at the earliest (IDLE → REQ).

Optional Feature:
- Macro: INTR_NEST_EN.
- Defined: eligibility as above. A higher-priority source preempts a running handler, with multiple IN_SERVICE bits set concurrently.
- Undefined: E is forced to 0 whenever IN_SERVICE≠0. At most one IN_SERVICE bit is ever set, and MRET always clears it.

Test Plan:
- Reset, MASK=6'h3F, GIE=1, INTR=6'b000100, ack 3 cycles after INT_REQ:
  - INT_REQ rises 1 cycle after INTR is sampled, INT_ID=3, INT_ADDR=32'h120.
  - On ack: CLR=6'b000100 for 1 cycle and IN_SERVICE=6'b000100.
  - After MRET: IN_SERVICE=0.
- INTR=6'b100001 simultaneously:
  - INT_ID=1 first.
  - After ack and MRET: INT_ID=6, INT_ADDR=32'h150.
- INTR_NEST_EN defined, IN_SERVICE=6'b001000, INTR1 asserted:
  - Request id 1; after ack, IN_SERVICE=6'b001001.
  - First MRET leaves 6'b001000.
- INTR_NEST_EN undefined, same stimulus: no INT_REQ until MRET clears 6'b001000; then id 1 is served.
- Request pending, GIE dropped before ack: INT_REQ falls next cycle, CLR stays 0, and INTR stays asserted. Re-raising GIE re-requests the same id.
- Edge cases:
  - MRET with IN_SERVICE=0: MRET_ERR=1 and stays 1.
  - RST_N pulsed low while INT_REQ=1: all outputs 0 immediately, without waiting for a clock edge.
